// File: rtl/sprite_mapper.sv
// Pipelined sprite renderer: places a scaled, animated, paletted image at a
// runtime position and produces a registered colour plus an opaque-hit flag.
module sprite_mapper #(
   parameter int unsigned IMG_W             = 16,
   parameter int unsigned IMG_H             = 16,
   parameter int unsigned SCALE_SHIFT       = 2,
   parameter int unsigned NUM_FRAMES        = 4,
   parameter int unsigned PIXEL_BITS        = 3,
   parameter int unsigned ROM_LATENCY       = 1,
   parameter int unsigned FRAME_HOLD        = 8,
   parameter bit          TRANSPARENT_EN    = 1'b1,
   parameter int unsigned TRANSPARENT_INDEX = 0,
   localparam int unsigned ADDR_W           = $clog2(NUM_FRAMES * IMG_W * IMG_H)
) (
   input  logic                  vga_clk,
   input  logic                  reset_n,
   input  logic [9:0]            DrawX,
   input  logic [9:0]            DrawY,
   input  logic                  blank,
   input  logic                  frame_start,
   input  logic [9:0]            pos_x,
   input  logic [9:0]            pos_y,
   input  logic                  anim_en,
   output logic [ADDR_W-1:0]     rom_address,
   input  logic [PIXEL_BITS-1:0] rom_q,
   output logic [PIXEL_BITS-1:0] pal_index,
   input  logic [3:0]            pal_red,
   input  logic [3:0]            pal_green,
   input  logic [3:0]            pal_blue,
   output logic [3:0]            red,
   output logic [3:0]            green,
   output logic [3:0]            blue,
   output logic                  hit
);

   localparam int unsigned LX_W      = $clog2(IMG_W);
   localparam int unsigned LY_W      = $clog2(IMG_H);
   localparam int unsigned FR_W      = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;
   localparam int unsigned HOLD_W    = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1;
   localparam int unsigned SPAN_X    = IMG_W << SCALE_SHIFT;
   localparam int unsigned SPAN_Y    = IMG_H << SCALE_SHIFT;
   localparam int unsigned FRAME_PIX = IMG_W * IMG_H;

   logic [9:0]             pos_x_q;
   logic [9:0]             pos_y_q;
   logic [FR_W-1:0]        frame_idx;
   logic [HOLD_W-1:0]      hold_cnt;

   logic [10:0]            rel_x;
   logic [10:0]            rel_y;
   logic                   inside_c;
   logic [LX_W-1:0]        lx;
   logic [LY_W-1:0]        ly;
   logic [ADDR_W-1:0]      addr_c;

   logic                   inside_s1;
   logic                   blank_s1;
   logic [ROM_LATENCY-1:0] inside_pipe;
   logic [ROM_LATENCY-1:0] blank_pipe;
   logic                   opaque_c;

   // Position latch and animation stepping, both updated only at frame_start
   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         pos_x_q   <= '0;
         pos_y_q   <= '0;
         frame_idx <= '0;
         hold_cnt  <= '0;
      end else if (frame_start) begin
         pos_x_q <= pos_x;
         pos_y_q <= pos_y;
         if (anim_en) begin
            if (hold_cnt == HOLD_W'(FRAME_HOLD - 1)) begin
               hold_cnt <= '0;
               if (frame_idx == FR_W'(NUM_FRAMES - 1))
                  frame_idx <= '0;
               else
                  frame_idx <= frame_idx + FR_W'(1);
            end else begin
               hold_cnt <= hold_cnt + HOLD_W'(1);
            end
         end
      end
   end

   // Stage 0: bounds test and source-pixel coordinates; bit 10 is the borrow
   always_comb begin
      rel_x    = {1'b0, DrawX} - {1'b0, pos_x_q};
      rel_y    = {1'b0, DrawY} - {1'b0, pos_y_q};
      inside_c = !rel_x[10] && !rel_y[10] &&
                 (rel_x < 11'(SPAN_X)) && (rel_y < 11'(SPAN_Y));
      lx       = rel_x[SCALE_SHIFT +: LX_W];
      ly       = rel_y[SCALE_SHIFT +: LY_W];
      addr_c   = '0;
      if (inside_c)
         addr_c = (ADDR_W'(frame_idx) * ADDR_W'(FRAME_PIX)) + ADDR_W'({ly, lx});
   end

   // Stage 1 address register, then delay inside/blank to line up with rom_q
   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         rom_address <= '0;
         inside_s1   <= 1'b0;
         blank_s1    <= 1'b0;
         inside_pipe <= '0;
         blank_pipe  <= '0;
      end else begin
         rom_address    <= addr_c;
         inside_s1      <= inside_c;
         blank_s1       <= blank;
         inside_pipe[0] <= inside_s1;
         blank_pipe[0]  <= blank_s1;
         for (int i = 1; i < int'(ROM_LATENCY); i++) begin
            inside_pipe[i] <= inside_pipe[i-1];
            blank_pipe[i]  <= blank_pipe[i-1];
         end
      end
   end

   assign pal_index = rom_q;

   // Opaque when inside the sprite, in active video and not the key colour
   always_comb begin
      opaque_c = inside_pipe[ROM_LATENCY-1] && blank_pipe[ROM_LATENCY-1];
      if (TRANSPARENT_EN && (rom_q == PIXEL_BITS'(TRANSPARENT_INDEX)))
         opaque_c = 1'b0;
   end

   // Output colour register
   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         red   <= '0;
         green <= '0;
         blue  <= '0;
         hit   <= 1'b0;
      end else if (opaque_c) begin
         red   <= pal_red;
         green <= pal_green;
         blue  <= pal_blue;
         hit   <= 1'b1;
      end else begin
         red   <= '0;
         green <= '0;
         blue  <= '0;
         hit   <= 1'b0;
      end
   end

endmodule

// File: tb/tb_sprite_mapper.sv
// Directed bench for sprite_mapper: addressing, latency, transparency,
// animation stepping, position latching and asynchronous reset.
module tb_sprite_mapper;

   localparam int unsigned ADDR_W = 10;

   logic        vga_clk = 1'b0;
   logic        reset_n;
   logic [9:0]  DrawX, DrawY, pos_x, pos_y;
   logic        blank, frame_start, anim_en;

   logic [ADDR_W-1:0] rom_address0, rom_address1;
   logic [2:0]        rom_q0, rom_q1, pal_index0, pal_index1;
   logic [3:0]        pal_r0, pal_g0, pal_b0, pal_r1, pal_g1, pal_b1;
   logic [3:0]        red0, green0, blue0, red1, green1, blue1;
   logic              hit0, hit1;

   logic [2:0] rom [0:1023];

   int n_checks = 0;
   int n_fail   = 0;

   always #5 vga_clk = ~vga_clk;

   sprite_mapper dut0 (
      .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(DrawX), .DrawY(DrawY),
      .blank(blank), .frame_start(frame_start), .pos_x(pos_x), .pos_y(pos_y),
      .anim_en(anim_en), .rom_address(rom_address0), .rom_q(rom_q0),
      .pal_index(pal_index0), .pal_red(pal_r0), .pal_green(pal_g0),
      .pal_blue(pal_b0), .red(red0), .green(green0), .blue(blue0), .hit(hit0)
   );

   sprite_mapper #(.TRANSPARENT_EN(1'b0)) dut1 (
      .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(DrawX), .DrawY(DrawY),
      .blank(blank), .frame_start(frame_start), .pos_x(pos_x), .pos_y(pos_y),
      .anim_en(anim_en), .rom_address(rom_address1), .rom_q(rom_q1),
      .pal_index(pal_index1), .pal_red(pal_r1), .pal_green(pal_g1),
      .pal_blue(pal_b1), .red(red1), .green(green1), .blue(blue1), .hit(hit1)
   );

   // Image ROM model with one cycle of read latency
   always @(posedge vga_clk) begin
      rom_q0 <= rom[rom_address0];
      rom_q1 <= rom[rom_address1];
   end

   function automatic logic [11:0] pal(input logic [2:0] idx);
      case (idx)
         3'd5:    pal = 12'hF80;
         3'd0:    pal = 12'h123;
         default: pal = {1'b0, idx, 1'b0, idx, 1'b0, idx};
      endcase
   endfunction

   // Palette model, combinational from the index
   always_comb begin
      {pal_r0, pal_g0, pal_b0} = pal(pal_index0);
      {pal_r1, pal_g1, pal_b1} = pal(pal_index1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge vga_clk);
         #1;
      end
   endtask

   task automatic pulse_frames(input int n);
      for (int i = 0; i < n; i++) begin
         frame_start = 1'b1;
         step(1);
         frame_start = 1'b0;
         step(1);
      end
   endtask

   task automatic addr_at(input string tag, input int x, input int y, input int exp);
      DrawX = 10'(x);
      DrawY = 10'(y);
      step(1);
      check(tag, 32'(rom_address0), 32'(exp));
   endtask

   task automatic pix_at(input string tag, input int x, input int y,
                         input logic exp_hit, input logic [11:0] exp_rgb);
      DrawX = 10'(x);
      DrawY = 10'(y);
      step(3);
      check({tag, "_hit"}, 32'(hit0), 32'(exp_hit));
      check({tag, "_rgb"}, 32'({red0, green0, blue0}), 32'(exp_rgb));
   endtask

   initial begin
      for (int a = 0; a < 1024; a++) rom[a] = 3'd5;
      rom[1] = 3'd0;

      reset_n = 1'b0; DrawX = '0; DrawY = '0; blank = 1'b0;
      frame_start = 1'b0; pos_x = 10'd100; pos_y = 10'd50; anim_en = 1'b0;
      #22;
      check("rst_addr", 32'(rom_address0), 32'd0);
      check("rst_hit",  32'(hit0), 32'd0);
      check("rst_rgb",  32'({red0, green0, blue0}), 32'd0);
      reset_n = 1'b1;
      step(1);
      pulse_frames(1);
      blank = 1'b1;

      // Addressing around pos (100,50), frame 0
      addr_at("addr_100_50", 100, 50, 0);
      addr_at("addr_103_50", 103, 50, 0);
      addr_at("addr_104_50", 104, 50, 1);
      addr_at("addr_163_50", 163, 50, 15);
      addr_at("addr_100_54", 100, 54, 16);
      addr_at("addr_163_113", 163, 113, 255);

      // Edges: right/bottom exclusive, left outside
      pix_at("edge_164", 164, 50, 1'b0, 12'h000);
      pix_at("edge_99",  99,  50, 1'b0, 12'h000);
      pix_at("edge_y114", 100, 114, 1'b0, 12'h000);

      // Exact three-cycle latency to a coloured pixel
      DrawX = 10'd100; DrawY = 10'd50;
      step(2);
      check("lat2_hit", 32'(hit0), 32'd0);
      step(1);
      check("lat3_hit", 32'(hit0), 32'd1);
      check("lat3_rgb", 32'({red0, green0, blue0}), 32'hF80);
      check("lat3_rgb_nt", 32'({red1, green1, blue1}), 32'hF80);

      // Blanking suppresses output
      blank = 1'b0;
      pix_at("blank0", 100, 50, 1'b0, 12'h000);
      blank = 1'b1;

      // Transparent index versus transparency disabled
      pix_at("transp", 104, 50, 1'b0, 12'h000);
      check("notransp_hit", 32'(hit1), 32'd1);
      check("notransp_rgb", 32'({red1, green1, blue1}), 32'h123);

      // Animation stepping
      anim_en = 1'b1;
      pulse_frames(7);
      addr_at("anim_7", 100, 50, 0);
      pulse_frames(1);
      addr_at("anim_8", 100, 50, 256);
      anim_en = 1'b0;
      pulse_frames(5);
      addr_at("anim_hold", 100, 50, 256);
      anim_en = 1'b1;
      pulse_frames(8);
      addr_at("anim_16", 100, 50, 512);
      pulse_frames(16);
      addr_at("anim_wrap", 100, 50, 0);
      anim_en = 1'b0;

      // Position change ignored until next frame_start
      pos_x = 10'd200;
      addr_at("pos_old", 104, 50, 1);
      pulse_frames(1);
      addr_at("pos_new", 204, 50, 1);
      pix_at("pos_new_pix", 200, 50, 1'b1, 12'hF80);
      pix_at("pos_old_pix", 104, 50, 1'b0, 12'h000);

      // Asynchronous reset mid-line with a sprite hit on screen
      anim_en = 1'b1;
      pulse_frames(8);
      addr_at("pre_rst_addr", 200, 50, 256);
      pix_at("pre_rst_pix", 200, 50, 1'b1, 12'hF80);
      #2 reset_n = 1'b0;
      #1;
      check("async_hit",  32'(hit0), 32'd0);
      check("async_rgb",  32'({red0, green0, blue0}), 32'd0);
      check("async_addr", 32'(rom_address0), 32'd0);
      #3 reset_n = 1'b1;
      anim_en = 1'b0;
      pix_at("post_rst_unlatched", 200, 50, 1'b0, 12'h000);
      pulse_frames(1);
      addr_at("post_rst_f0", 204, 50, 1);
      addr_at("post_rst_f0b", 200, 50, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
